esop_seq_eval: RTL and testbench

ESOP_SEQ_EVAL -- requirements
Module: esop_seq_eval

---
 rtl/esop_seq_eval_if.sv | 51 +++++
 rtl/esop_seq_eval.sv | 154 +++++++++++++++
 tb/tb_esop_seq_eval.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/esop_seq_eval_if.sv
// Bundle of configuration, input-vector and result signals for esop_seq_eval.
// out_cnt exists only when ESOP_CUBE_CNT_EN is defined.
interface esop_seq_eval_if #(
  parameter int NVARS  = 50,
  parameter int NCUBES = 64,
  parameter int NOUT   = 1
);
  localparam int AW = (NCUBES > 1) ? $clog2(NCUBES) : 1;
  localparam int LW = $clog2(NCUBES + 1);

  // cube memory / length configuration
  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [NVARS-1:0] cfg_pos;
  logic [NVARS-1:0] cfg_neg;
  logic [NOUT-1:0]  cfg_omask;
  logic             cfg_len_we;
  logic [LW-1:0]    cfg_len;

  // input vector handshake
  logic             in_valid;
  logic             in_ready;
  logic [NVARS-1:0] in_x;

  // result handshake
  logic             out_valid;
  logic             out_ready;
  logic [NOUT-1:0]  out_f;
  logic             busy;
`ifdef ESOP_CUBE_CNT_EN
  logic [LW-1:0]    out_cnt;
`endif

  modport master (
    output cfg_we, cfg_addr, cfg_pos, cfg_neg, cfg_omask, cfg_len_we, cfg_len,
    output in_valid, in_x, out_ready,
    input  in_ready, out_valid, out_f, busy
`ifdef ESOP_CUBE_CNT_EN
    , input out_cnt
`endif
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_pos, cfg_neg, cfg_omask, cfg_len_we, cfg_len,
    input  in_valid, in_x, out_ready,
    output in_ready, out_valid, out_f, busy
`ifdef ESOP_CUBE_CNT_EN
    , output out_cnt
`endif
  );
endinterface

// File: rtl/esop_seq_eval.sv
// Sequential ESOP evaluator: walks the active cubes one per cycle and XOR-
// accumulates each cube's output mask into the result.
// Optional feature macro ESOP_CUBE_CNT_EN adds out_cnt (count of true cubes).
module esop_seq_eval #(
  parameter int NVARS  = 50,
  parameter int NCUBES = 64,
  parameter int NOUT   = 1
) (
  input  logic          clk,
  input  logic          rst,
  esop_seq_eval_if.slave bus
);
  localparam int AW = (NCUBES > 1) ? $clog2(NCUBES) : 1;
  localparam int LW = $clog2(NCUBES + 1);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;

  state_t state_q, state_d;

  // cube memory (not reset; len gates its use)
  logic [NVARS-1:0] mem_pos   [NCUBES];
  logic [NVARS-1:0] mem_neg   [NCUBES];
  logic [NOUT-1:0]  mem_omask [NCUBES];

  logic [LW-1:0]    len_q;
  logic [LW-1:0]    idx_q;
  logic [NOUT-1:0]  acc_q;
  logic [NVARS-1:0] x_q;

  // one-stage pipeline between cube lookup and accumulation
  logic             pv_q;
  logic [NOUT-1:0]  term_q;
  logic             hit_q;
`ifdef ESOP_CUBE_CNT_EN
  logic [LW-1:0]    cnt_q;
`endif

  logic [AW-1:0]    rd_addr;
  logic [NVARS-1:0] rd_pos;
  logic [NVARS-1:0] rd_neg;
  logic [NOUT-1:0]  rd_omask;
  logic             cube_true;
  logic             idle;
  logic [LW-1:0]    len_sat;

  assign idle = (state_q == S_IDLE);

  // cube lookup and truth evaluation for the entry at idx
  always_comb begin
    rd_addr   = idx_q[AW-1:0];
    rd_pos    = mem_pos[rd_addr];
    rd_neg    = mem_neg[rd_addr];
    rd_omask  = mem_omask[rd_addr];
    cube_true = ((x_q & rd_pos) == rd_pos) && ((~x_q & rd_neg) == rd_neg);
  end

  // saturate requested length to memory depth
  always_comb begin
    len_sat = bus.cfg_len;
    if (bus.cfg_len > LW'(NCUBES)) len_sat = LW'(NCUBES);
  end

  // configuration writes, accepted only while idle
  always_ff @(posedge clk) begin
    if (idle && bus.cfg_we) begin
      mem_pos[bus.cfg_addr]   <= bus.cfg_pos;
      mem_neg[bus.cfg_addr]   <= bus.cfg_neg;
      mem_omask[bus.cfg_addr] <= bus.cfg_omask;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; EVAL ends once every active cube has been issued and
  // the last pipelined term is folded in (len=0 also passes through EVAL so
  // that the result latency is uniformly len+1 cycles)
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.in_valid) state_d = S_EVAL;
      S_EVAL: if (idx_q == len_q) state_d = S_DONE;
      S_DONE: if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // output decode
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
    bus.busy      = (state_q == S_EVAL) || (state_q == S_DONE);
    bus.out_f     = acc_q;
`ifdef ESOP_CUBE_CNT_EN
    bus.out_cnt   = cnt_q;
`endif
  end

  // datapath: length register, vector capture, issue and accumulate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      idx_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      pv_q   <= 1'b0;
      term_q <= '0;
      hit_q  <= 1'b0;
`ifdef ESOP_CUBE_CNT_EN
      cnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cfg_len_we) len_q <= len_sat;
          if (bus.in_valid) begin
            x_q   <= bus.in_x;
            acc_q <= '0;
            idx_q <= '0;
            pv_q  <= 1'b0;
`ifdef ESOP_CUBE_CNT_EN
            cnt_q <= '0;
`endif
          end
        end
        S_EVAL: begin
          if (pv_q) begin
            acc_q <= acc_q ^ term_q;
`ifdef ESOP_CUBE_CNT_EN
            cnt_q <= cnt_q + LW'(hit_q);
`endif
          end
          if (idx_q != len_q) begin
            term_q <= rd_omask & {NOUT{cube_true}};
            hit_q  <= cube_true;
            pv_q   <= 1'b1;
            idx_q  <= idx_q + LW'(1);
          end else begin
            pv_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifndef ESOP_CUBE_CNT_EN
  logic unused_hit;
  assign unused_hit = hit_q;
`endif
endmodule

// File: tb/tb_esop_seq_eval.sv
// Directed self-checking bench for esop_seq_eval (NVARS=4, NCUBES=8, NOUT=2).
module tb_esop_seq_eval;
  localparam int NVARS  = 4;
  localparam int NCUBES = 8;
  localparam int NOUT   = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  esop_seq_eval_if #(.NVARS(NVARS), .NCUBES(NCUBES), .NOUT(NOUT)) bus ();

  esop_seq_eval #(.NVARS(NVARS), .NCUBES(NCUBES), .NOUT(NOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_cube(input logic [2:0] a, input logic [3:0] p,
                            input logic [3:0] n, input logic [1:0] om);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_pos   = p;
    bus.cfg_neg   = n;
    bus.cfg_omask = om;
    tick();
    bus.cfg_we    = 1'b0;
  endtask

  task automatic set_len(input logic [3:0] l);
    bus.cfg_len_we = 1'b1;
    bus.cfg_len    = l;
    tick();
    bus.cfg_len_we = 1'b0;
  endtask

  task automatic start(input string tag, input logic [3:0] x);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_x     = x;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag, input int lat, input logic [1:0] f,
                             input int cnt);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_f"}, 32'(bus.out_f), 32'(f));
`ifdef ESOP_CUBE_CNT_EN
    chk({tag, "_cnt"}, 32'(bus.out_cnt), 32'(cnt));
`else
    if (cnt < 0) $display("unexpected count argument");
`endif
  endtask

  task automatic pop(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_pop_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_pop_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run(input string tag, input logic [3:0] x, input int lat,
                     input logic [1:0] f, input int cnt);
    start(tag, x);
    wait_result(tag, lat, f, cnt);
    pop(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  seen;
    rst            = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_addr   = '0;
    bus.cfg_pos    = '0;
    bus.cfg_neg    = '0;
    bus.cfg_omask  = '0;
    bus.cfg_len_we = 1'b0;
    bus.cfg_len    = '0;
    bus.in_valid   = 1'b0;
    bus.in_x       = '0;
    bus.out_ready  = 1'b0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_out_f", 32'(bus.out_f), 32'd0);

    // len=0 after reset: result one cycle after accept, all zero
    start("len0", 4'b1010);
    chk("len0_busy", 32'(bus.busy), 32'd1);
    wait_result("len0", 1, 2'b00, 0);
    pop("len0");

    // two single-literal cubes on output 0
    write_cube(3'd0, 4'b0001, 4'b0000, 2'b01);
    write_cube(3'd1, 4'b0010, 4'b0000, 2'b01);
    set_len(4'd2);
    run("pair_x3", 4'b0011, 3, 2'b00, 2);
    run("pair_x1", 4'b0001, 3, 2'b01, 1);
    run("pair_x0", 4'b0000, 3, 2'b00, 0);

    // constant-1 cube plus contradictory (constant-0) cube
    write_cube(3'd0, 4'b0000, 4'b0000, 2'b11);
    write_cube(3'd1, 4'b1000, 4'b1000, 2'b11);
    run("const_x5", 4'b0101, 3, 2'b11, 1);
    run("const_xf", 4'b1111, 3, 2'b11, 1);

    // mixed positive/negative literals, both outputs
    write_cube(3'd0, 4'b0001, 4'b0010, 2'b01);
    write_cube(3'd1, 4'b0000, 4'b1000, 2'b10);
    write_cube(3'd2, 4'b0100, 4'b0000, 2'b11);
    set_len(4'd3);
    run("mix_x5", 4'b0101, 4, 2'b00, 3);
    run("mix_x9", 4'b1001, 4, 2'b01, 1);
    run("mix_x6", 4'b0110, 4, 2'b01, 2);
    run("mix_xe", 4'b1110, 4, 2'b11, 1);

    // config writes during EVAL are ignored; DONE holds under backpressure
    start("hold", 4'b0101);
    bus.cfg_we     = 1'b1;
    bus.cfg_addr   = 3'd2;
    bus.cfg_pos    = 4'b0000;
    bus.cfg_neg    = 4'b0000;
    bus.cfg_omask  = 2'b00;
    bus.cfg_len_we = 1'b1;
    bus.cfg_len    = 4'd1;
    tick();
    bus.cfg_we     = 1'b0;
    bus.cfg_len_we = 1'b0;
    wait_result("hold", 3, 2'b00, 3);
    bus.in_valid = 1'b1;
    bus.in_x     = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_out_f", 32'(bus.out_f), 32'd0);
      chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("hold_no_accept_busy", 32'(bus.busy), 32'd0);
    chk("hold_no_accept_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    run("mem_kept", 4'b0101, 4, 2'b00, 3);

    // write and accept in the same idle cycle: new entry is used
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'd2;
    bus.cfg_pos   = 4'b0000;
    bus.cfg_neg   = 4'b0000;
    bus.cfg_omask = 2'b00;
    start("wr_same", 4'b0101);
    bus.cfg_we    = 1'b0;
    wait_result("wr_same", 4, 2'b11, 3);
    pop("wr_same");

    // oversize length saturates to memory depth
    for (int unsigned k = 3; k < 8; k++)
      write_cube(3'(k), 4'b0000, 4'b0000, 2'b01);
    set_len(4'd15);
    run("sat", 4'b0101, 9, 2'b10, 8);

    // reset in the middle of EVAL aborts the vector and clears len
    start("abort", 4'b0101);
    tick();
    tick();
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busy_async", 32'(bus.busy), 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("abort_no_out_valid", 32'(seen), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    run("after_abort", 4'b0101, 1, 2'b00, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
